serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor built around one full-subtractor cell.
- The cell computes D = A^B^Ci and Co = (~A&B)|(~A&Ci)|(B&Ci).
- The block owns the cell's surrounding datapath: it supplies A/B bits LSB-first, registers Co back into Ci each cycle, and assembles the D bits into a WIDTH-bit difference.
- A start/busy/done handshake faces the upstream requester.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
clk         input   1      rising-edge clock
rst_n       input   1      asynchronous active-low reset
start       input   1      request; sampled only when busy=0
a           input   WIDTH  minuend; captured on the accepted start
b           input   WIDTH  subtrahend; captured on the accepted start
bin         input   1      initial borrow-in; captured on the accepted start
busy        output  1      high while an operation is in progress
done        output  1      one-cycle pulse when the result is valid
diff        output  WIDTH  a - b - bin, modulo 2^WIDTH
borrow_out  output  1      final Co of the MSB cell (1 = unsigned underflow)
ovf         output  1      signed overflow flag (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- While rst_n=0, all of the following are 0: state=IDLE, busy, done, diff, borrow_out, ovf, bit counter, operand shift registers, borrow register and partial-result register.
- States:
  - IDLE: on an edge with start=1, load a_sh<=a, b_sh<=b, brw<=bin, cnt<=0, set busy<=1, go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: each edge processes one bit through the cell.
    - Cell inputs: A=a_sh[0], B=b_sh[0], Ci=brw.
    - Updates: brw<=Co; a_sh and b_sh shift right by 1; D shifts into the MSB of the partial-result register; cnt<=cnt+1.
    - On the edge where cnt==WIDTH-1: diff<=completed result, borrow_out<=Co, done<=1, busy<=0, go to IDLE.
- Latency:
  - start accepted at edge T; bits processed at edges T+1..T+WIDTH.
  - done is high for exactly the one cycle following edge T+WIDTH.
  - Throughput is one operation per WIDTH+1 cycles.
- diff and borrow_out change only at a completion edge. They hold their value until the next completion or reset. The partial result is never visible on diff.
- done is a single-cycle pulse; it deasserts on the next edge unconditionally.
- start while busy=1: ignored, with no effect on operands or the running operation. start is level-sampled; a held start re-launches on each edge where busy=0.
- start during the done cycle: accepted, because busy=0 in that cycle. The new operation begins and the previous diff stays held until the new completion.
- a, b and bin are don't-care except on the accepting edge.
- Reset mid-operation: the operation is abandoned, all state returns to reset values, and no done pulse is issued.
- Wrap-around: diff is modulo 2^WIDTH; borrow_out=1 exactly when a < b+bin as unsigned values.
- cnt width is clog2(WIDTH). cnt never exceeds WIDTH-1.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN
- Defined:
  - At the completion edge, ovf <= (a_msb != b_msb) && (diff_msb != a_msb).
  - a_msb and b_msb are the MSBs of the captured operands, held in a dedicated register loaded at start.
  - ovf updates and holds with the same timing as diff.
- Undefined:
  - ovf is tied to 0.
  - No MSB-capture registers are instantiated.
  - The port list is unchanged.

Test Plan:
- Reset, then a=8'h5A, b=8'h3C, bin=0, start pulse -> done exactly 8 cycles after the start edge; diff=8'h1E, borrow_out=0.
- a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, borrow_out=1. Then a=8'h10, b=8'h0F, bin=1 -> diff=8'h00, borrow_out=0.
- Launch a=8'hFF, b=8'h01; assert start with a=8'h00, b=8'h00 on every edge while busy -> diff=8'hFE. Result shows no corruption from the ignored starts. Then issue a back-to-back start in the done cycle and check it is accepted.
- Drop rst_n for 1 cycle at bit 4 of a=8'hAA-8'h55 -> busy, done and diff all 0 immediately; no done pulse follows. A subsequent 8'hAA-8'h55 gives 8'h55.
- With SERIAL_SUBTRACTOR_OVF_EN defined:
  - 8'h80-8'h01 -> diff=8'h7F, ovf=1.
  - 8'h7F-8'hFF -> diff=8'h80, ovf=1.
  - 8'h05-8'h03 -> ovf=0.
- With the macro undefined: ovf stays 0 for all of the above.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor around one full-subtractor cell; optional signed overflow via SERIAL_SUBTRACTOR_OVF_EN.
// Latency WIDTH cycles from accepted start to done pulse; start is ignored while busy (no queuing).
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] res_q, res_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  logic cell_a, cell_b, cell_d, cell_co;

  // The single full-subtractor cell.
  assign cell_a  = a_sh_q[0];
  assign cell_b  = b_sh_q[0];
  assign cell_d  = cell_a ^ cell_b ^ brw_q;
  assign cell_co = (~cell_a & cell_b) | (~cell_a & brw_q) | (cell_b & brw_q);

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    brw_d    = brw_q;
    res_d    = res_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          brw_d   = bin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        brw_d  = cell_co;
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = {cell_d, res_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Last bit: publish the finished word; cnt parks at 0 so it never passes WIDTH-1.
          diff_d   = {cell_d, res_q[WIDTH-1:1]};
          borrow_d = cell_co;
          cnt_d    = '0;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          ovf_d    = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      brw_q    <= 1'b0;
      res_q    <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      brw_q    <= brw_d;
      res_q    <= res_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign ovf        = ovf_q;
`else
  assign ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table plus hand sequences, results via a scoreboard queue.
module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy, done, borrow_out, ovf;
  logic [W-1:0] diff;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic ovf_exp(input logic v);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    return v;
`else
    return 1'b0;
`endif
  endfunction

  function automatic exp_t mk_exp(input logic [W-1:0] d, input logic bo, input logic ov);
    exp_t e;
    e.d  = d;
    e.bo = bo;
    e.ov = ovf_exp(ov);
    return e;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        e = sb.pop_front();
        check("diff", diff, e.d);
        check("borrow_out", borrow_out, e.bo);
        check("ovf", ovf, e.ov);
      end
    end
  end

  // Called on the negedge after the accepting edge; done must appear after edge T+W.
  task automatic wait_done(input string name);
    bit seen = 0;
    for (int k = 1; k <= W + 3; k++) begin
      @(negedge clk);
      if (done) begin
        check({name, "_latency"}, k, W);
        seen = 1;
        break;
      end
    end
    if (!seen) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic run_op(input string name, input vec_t v);
    a = v.a; b = v.b; bin = v.bin; start = 1'b1;
    sb.push_back(mk_exp(v.d, v.bo, v.ov));
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy_after_start"}, busy, 1);
    wait_done(name);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[8] = '{8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1};
    vecs[9] = '{8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow_out, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i]);
      @(negedge clk);
    end

    // Held start while busy must be ignored, then re-launch in the done cycle.
    begin : ignored_starts
      bit seen = 0;
      a = 8'hFF; b = 8'h01; bin = 1'b0; start = 1'b1;
      sb.push_back(mk_exp(8'hFE, 1'b0, 1'b0));
      @(negedge clk);
      a = 8'h00; b = 8'h00;
      for (int k = 1; k <= W + 3; k++) begin
        @(negedge clk);
        if (done) begin
          check("ignored_latency", k, W);
          check("done_cycle_busy", busy, 0);
          seen = 1;
          break;
        end
      end
      if (!seen) check("ignored_timeout", 0, 1);
      a = 8'h10; b = 8'h0F; bin = 1'b1;
      sb.push_back(mk_exp(8'h00, 1'b0, 1'b0));
      @(negedge clk);
      start = 1'b0;
      check("b2b_accepted_busy", busy, 1);
      check("b2b_done_pulse_width", done, 0);
      check("b2b_diff_held", diff, 8'hFE);
      wait_done("b2b");
      @(negedge clk);
    end

    // Nonzero diff before the abort so a cleared diff is observable.
    run_op("pre_abort", vecs[9]);
    @(negedge clk);

    a = 8'hAA; b = 8'h55; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_diff", diff, 0);
    check("abort_borrow", borrow_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    check("abort_no_done_busy", busy, 0);

    run_op("post_abort", vecs[8]);
    @(negedge clk);
    check("done_single_pulse", done, 0);
    check("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
